// File: rtl/niosii_system_sysid_checker.sv
// niosii_system_sysid_checker
// Avalon-MM master that reads the sysid slave (ID at word 0, build timestamp
// at word 1), latches both words and compares them against compile-time
// expected values. Status is fully registered for boot control and LEDs.
// Optional feature macro: SYSID_CHECKER_PERIODIC_EN -- when defined, the check
// reruns automatically every RECHECK_PERIOD cycles spent in DONE.
module niosii_system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'h00000000,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h5892649F,
  parameter int          READ_LATENCY       = 0,
  parameter int          TIMEOUT_CYCLES     = 255,
  parameter int          RECHECK_PERIOD     = 50000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic [31:0] id_value,
  output logic [31:0] timestamp_value,
  output logic        busy,
  output logic        done,
  output logic        match,
  output logic        mismatch_id,
  output logic        mismatch_ts,
  output logic        timeout
);

  typedef enum logic [2:0] {
    IDLE, REQ_ID, LAT_ID, REQ_TS, LAT_TS, CHECK, DONE
  } state_t;

  localparam bit          ZERO_LAT = (READ_LATENCY == 0);
  localparam logic [1:0]  LAT_LAST = ZERO_LAT ? 2'd0 : 2'(READ_LATENCY - 1);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nx;
  logic [15:0] stall_cnt;
  logic [1:0]  lat_cnt;
  logic        accept, stall_hit, cap_id, cap_ts, restart, recheck_hit;

  // avm_read is registered and only ever high in REQ_x, so it doubles as the
  // "in a request state" qualifier for acceptance and stall detection.
  assign accept    = avm_read & ~avm_waitrequest;
  assign stall_hit = avm_read & avm_waitrequest & (stall_cnt == TO_LAST);
  assign restart   = start | recheck_hit;

  // Data capture point: acceptance cycle when there is no latency, otherwise
  // the last counted latency cycle.
  assign cap_id = ZERO_LAT ? (state == REQ_ID && accept)
                           : (state == LAT_ID && lat_cnt == LAT_LAST);
  assign cap_ts = ZERO_LAT ? (state == REQ_TS && accept)
                           : (state == LAT_TS && lat_cnt == LAT_LAST);

`ifdef SYSID_CHECKER_PERIODIC_EN
  logic [25:0] per_cnt;

  // Recheck timer: runs only while parked in DONE; start rearms it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                        per_cnt <= '0;
    else if (state != DONE || start)  per_cnt <= '0;
    else                              per_cnt <= per_cnt + 26'd1;
  end

  assign recheck_hit = (state == DONE) && (per_cnt == 26'(RECHECK_PERIOD - 1));
`else
  // No recheck timer in this build; the period parameter has no effect.
  assign recheck_hit = (RECHECK_PERIOD < 0);
`endif

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   state_nx = REQ_ID;
      REQ_ID: if (stall_hit)   state_nx = DONE;
              else if (accept) state_nx = ZERO_LAT ? REQ_TS : LAT_ID;
      LAT_ID: if (lat_cnt == LAT_LAST) state_nx = REQ_TS;
      REQ_TS: if (stall_hit)   state_nx = DONE;
              else if (accept) state_nx = ZERO_LAT ? CHECK : LAT_TS;
      LAT_TS: if (lat_cnt == LAT_LAST) state_nx = CHECK;
      CHECK:  state_nx = DONE;
      DONE:   if (restart) state_nx = REQ_ID;
      default: state_nx = IDLE;
    endcase
  end

  // State plus bus/busy outputs registered from the next state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      avm_read    <= 1'b0;
      avm_address <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nx;
      avm_read    <= (state_nx == REQ_ID) || (state_nx == REQ_TS);
      avm_address <= (state_nx == REQ_TS);
      busy        <= (state_nx != IDLE) && (state_nx != DONE);
    end
  end

  // Stall and latency counters; both restart whenever their state is entered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      lat_cnt   <= '0;
    end else begin
      if (state_nx != state)                 stall_cnt <= '0;
      else if (avm_read && avm_waitrequest)  stall_cnt <= stall_cnt + 16'd1;
      if ((state == LAT_ID || state == LAT_TS) && state_nx == state)
        lat_cnt <= lat_cnt + 2'd1;
      else
        lat_cnt <= '0;
    end
  end

  // Captured words survive timeouts and restarts until overwritten.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      id_value        <= '0;
      timestamp_value <= '0;
    end else begin
      if (cap_id) id_value        <= avm_readdata;
      if (cap_ts) timestamp_value <= avm_readdata;
    end
  end

  // Result flags: set on CHECK or timeout, held in DONE, cleared on restart.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      done        <= 1'b0;
      match       <= 1'b0;
      mismatch_id <= 1'b0;
      mismatch_ts <= 1'b0;
      timeout     <= 1'b0;
    end else if (stall_hit) begin
      done        <= 1'b1;
      match       <= 1'b0;
      mismatch_id <= 1'b0;
      mismatch_ts <= 1'b0;
      timeout     <= 1'b1;
    end else if (state == CHECK) begin
      done        <= 1'b1;
      mismatch_id <= (id_value != EXPECTED_ID);
      mismatch_ts <= (timestamp_value != EXPECTED_TIMESTAMP);
      match       <= (id_value == EXPECTED_ID) &&
                     (timestamp_value == EXPECTED_TIMESTAMP);
      timeout     <= 1'b0;
    end else if (state == DONE && restart) begin
      done        <= 1'b0;
      match       <= 1'b0;
      mismatch_id <= 1'b0;
      mismatch_ts <= 1'b0;
      timeout     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_niosii_system_sysid_checker.sv
// Bench for niosii_system_sysid_checker: two instances (zero latency with a
// short timeout, and READ_LATENCY=2) each driven by a small sysid slave model.
// Expected results are queued at stimulus time and popped when done rises.
module tb_niosii_system_sysid_checker;

  localparam logic [31:0] TS_OK = 32'h5892649F;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        m, mi, mt, to;
    logic [31:0] idv, tsv;
    int          lat, rds;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  // dut0: latency 0, timeout 8, period 100
  logic        rst0 = 1'b1, start0 = 1'b0, wait0 = 1'b0;
  logic [31:0] id0 = 32'h0, ts0 = TS_OK, rd0;
  logic        a0, r0, b0, dn0, m0, mi0, mt0, to0;
  logic [31:0] idv0, tsv0;

  // dut1: latency 2
  logic        rst1 = 1'b1, start1 = 1'b0, wait1 = 1'b0;
  logic [31:0] rd1;
  logic        a1, r1, b1, dn1, m1, mi1, mt1, to1;
  logic [31:0] idv1, tsv1;
  logic [1:0]  acc_q = '0, adr_q = '0;

  // Zero-latency slave: data valid during the acceptance cycle only.
  assign rd0 = (r0 && !wait0) ? (a0 ? ts0 : id0) : 32'hBAD0BAD0;

  // Two-cycle slave: data valid exactly two cycles after acceptance.
  always @(posedge clock) begin
    acc_q <= {acc_q[0], r1 & ~wait1};
    adr_q <= {adr_q[0], a1};
  end
  assign rd1 = acc_q[1] ? (adr_q[1] ? TS_OK : 32'h0) : 32'hBAD1BAD1;

  niosii_system_sysid_checker #(
    .READ_LATENCY(0), .TIMEOUT_CYCLES(8), .RECHECK_PERIOD(100)
  ) dut0 (
    .clock(clock), .reset(rst0), .start(start0),
    .avm_address(a0), .avm_read(r0), .avm_waitrequest(wait0),
    .avm_readdata(rd0), .id_value(idv0), .timestamp_value(tsv0),
    .busy(b0), .done(dn0), .match(m0), .mismatch_id(mi0),
    .mismatch_ts(mt0), .timeout(to0)
  );

  niosii_system_sysid_checker #(
    .READ_LATENCY(2)
  ) dut1 (
    .clock(clock), .reset(rst1), .start(start1),
    .avm_address(a1), .avm_read(r1), .avm_waitrequest(wait1),
    .avm_readdata(rd1), .id_value(idv1), .timestamp_value(tsv1),
    .busy(b1), .done(dn1), .match(m1), .mismatch_id(mi1),
    .mismatch_ts(mt1), .timeout(to1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic m, mi, mt, to, input logic [31:0] idv, tsv,
                              input int lat, rds);
    exp_t e;
    e.m = m; e.mi = mi; e.mt = mt; e.to = to;
    e.idv = idv; e.tsv = tsv; e.lat = lat; e.rds = rds;
    return e;
  endfunction

  // Count edges until done, then pop the expected record and compare.
  task automatic wait_done(input int sel, input string tag);
    int   n = 0, rds = 0;
    exp_t e;
    logic d, rd;
    do begin
      @(posedge clock); #1;
      n++;
      if (n == 1) begin start0 = 1'b0; start1 = 1'b0; end
      d  = sel ? dn1 : dn0;
      rd = sel ? r1 : r0;
      if (rd) rds++;
    end while (!d && n < 300);
    if (sel ? (q1.size() == 0) : (q0.size() == 0)) begin
      chk({tag, ".queue"}, 0, 1);
      return;
    end
    e = sel ? q1.pop_front() : q0.pop_front();
    chk({tag, ".done"},  d, 1);
    chk({tag, ".lat"},   n, e.lat);
    chk({tag, ".reads"}, rds, e.rds);
    chk({tag, ".busy"},  sel ? b1 : b0, 0);
    chk({tag, ".match"}, sel ? m1 : m0, e.m);
    chk({tag, ".mis_id"}, sel ? mi1 : mi0, e.mi);
    chk({tag, ".mis_ts"}, sel ? mt1 : mt0, e.mt);
    chk({tag, ".tmo"},   sel ? to1 : to0, e.to);
    chk({tag, ".idv"},   sel ? idv1 : idv0, e.idv);
    chk({tag, ".tsv"},   sel ? tsv1 : tsv0, e.tsv);
  endtask

  task automatic kick0(input string tag, input exp_t e);
    @(negedge clock);
    q0.push_back(e);
    start0 = 1'b1;
    wait_done(0, tag);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk("rst.busy", b0, 0);
    chk("rst.done", dn0, 0);
    chk("rst.read", r0, 0);
    chk("rst.match", m0, 0);
    chk("rst.tsv", tsv1, 0);

    // Auto-start after reset release on both instances.
    q0.push_back(mk(1, 0, 0, 0, 32'h0, TS_OK, 4, 2));
    q1.push_back(mk(1, 0, 0, 0, 32'h0, TS_OK, 8, 2));
    rst0 = 1'b0; rst1 = 1'b0;
    fork
      wait_done(0, "auto0");
      wait_done(1, "auto1");
    join

    // Wrong timestamp, then wrong ID.
    ts0 = 32'h12345678;
    kick0("bad_ts", mk(0, 0, 1, 0, 32'h0, 32'h12345678, 4, 2));
    ts0 = TS_OK; id0 = 32'h1;
    kick0("bad_id", mk(0, 1, 0, 0, 32'h1, TS_OK, 4, 2));

    // Permanent stall: read held 8 cycles, captured words kept.
    wait0 = 1'b1;
    kick0("tmo", mk(0, 0, 0, 1, 32'h1, TS_OK, 9, 8));
    chk("tmo.read_low", r0, 0);
    wait0 = 1'b0; id0 = 32'h0;
    kick0("rerun0", mk(1, 0, 0, 0, 32'h0, TS_OK, 4, 2));

`ifdef SYSID_CHECKER_PERIODIC_EN
    begin
      int n = 0;
      do begin @(posedge clock); #1; n++; end while (!b0 && n < 300);
      chk("periodic.gap", n, 100);
      q0.push_back(mk(1, 0, 0, 0, 32'h0, TS_OK, 4, 2));
      wait_done(0, "periodic");
    end
`endif

    // Latency 2 with 3 wait cycles on the ID read; start mid-run ignored.
    @(negedge clock);
    q1.push_back(mk(1, 0, 0, 0, 32'h0, TS_OK, 11, 5));
    start1 = 1'b1; wait1 = 1'b1;
    fork
      wait_done(1, "lat_wait");
      begin
        repeat (4) @(negedge clock);
        wait1 = 1'b0;
        repeat (2) @(negedge clock);
        start1 = 1'b1;
        @(negedge clock);
        start1 = 1'b0;
      end
    join
    repeat (5) @(negedge clock);
    chk("noqueue.done", dn1, 1);
    chk("noqueue.busy", b1, 0);

    // Reset while in LAT_TS.
    @(negedge clock);
    start1 = 1'b1;
    @(posedge clock); #1 start1 = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    chk("latts.busy", b1, 1);
    chk("latts.read", r1, 0);
    #1 rst1 = 1'b1;
    #1;
    chk("midrst.read", r1, 0);
    chk("midrst.busy", b1, 0);
    chk("midrst.done", dn1, 0);
    chk("midrst.addr", a1, 0);
    chk("midrst.idv", idv1, 0);
    chk("midrst.tsv", tsv1, 0);
    @(negedge clock);
    q1.push_back(mk(1, 0, 0, 0, 32'h0, TS_OK, 8, 2));
    rst1 = 1'b0;
    wait_done(1, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/niosii_system_sysid_checker.md
# niosII_system_sysid_checker

Avalon-MM master that sits directly downstream of the system ID slave and consumes its `readdata`. After reset (or on request) it reads the ID word (address 0) and the build timestamp word (address 1), latches both, and compares them to compile-time expected values. It drives pass/fail/timeout status to the boot-control logic and the status LEDs, so a stale or mismatched FPGA image is caught before the Nios II software relies on it.

## Interface
- `EXPECTED_ID`, 32'h00000000, expected word at address 0.
- `EXPECTED_TIMESTAMP`, 32'h5892649F (1485989023), expected word at address 1.
- `READ_LATENCY`, 0, fixed cycles from read acceptance to valid `avm_readdata`; legal range 0..3.
- `TIMEOUT_CYCLES`, 255, max consecutive cycles `avm_waitrequest` may stall a read; legal range 1..65535.
- `RECHECK_PERIOD`, 50000000, cycles between automatic rechecks; used only when the Configuration macro is defined.

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle request to rerun the check.
- `avm_address`  out  1  word address to the sysid slave.
- `avm_read`  out  1  read request.
- `avm_waitrequest`  in  1  slave stall; tie 0 for the direct sysid connection.
- `avm_readdata`  in  32  read data.
- `id_value`  out  32  last ID word read.
- `timestamp_value`  out  32  last timestamp word read.
- `busy`  out  1  check in progress.
- `done`  out  1  check finished (pass, fail or timeout); held until next run.
- `match`  out  1  both words equal expected; valid when `done`.
- `mismatch_id`  out  1  ID word differs; valid when `done`.
- `mismatch_ts`  out  1  timestamp word differs; valid when `done`.
- `timeout`  out  1  a read stalled for `TIMEOUT_CYCLES`; valid when `done`.

## Operation
- States: IDLE, REQ_ID, LAT_ID, REQ_TS, LAT_TS, CHECK, DONE.
- IDLE: entered on reset; moves to REQ_ID on the first cycle after reset deasserts (auto-start), and on `start` from DONE.
- REQ_x: `avm_read`=1, `avm_address` = 0 (ID) or 1 (TS), both held stable until `avm_waitrequest`=0. Acceptance is the cycle with `avm_read`=1 and `avm_waitrequest`=0.
- LAT_x: counts `READ_LATENCY` cycles after acceptance; captures `avm_readdata` into `id_value`/`timestamp_value` on the data cycle. With `READ_LATENCY`=0, capture occurs in the acceptance cycle and LAT_x is skipped.
- CHECK: one cycle; computes `mismatch_id`, `mismatch_ts`, `match` = neither mismatch; then DONE.
- Timeout: 16-bit stall counter, cleared at each REQ entry, increments per REQ cycle with `avm_waitrequest`=1. On reaching `TIMEOUT_CYCLES`: drop `avm_read`, set `timeout`=1, `match`=0, mismatches=0, go to DONE. Captured values from any completed read are kept.
- DONE: `done`=1 and status held. `start` clears `done`, `match`, mismatches and `timeout` next cycle and enters REQ_ID; captured values are kept until overwritten.
- `start` while `busy` is ignored (not queued).
- `busy` = 1 in every state except IDLE and DONE.

## Timing
- Reset (async assert, sync release): all outputs 0, `avm_read`=0, state IDLE, counters 0.
- Reset mid-read: `avm_read` drops immediately; the outstanding read is abandoned and the late data is not captured.
- All outputs are registered; no combinational path from `avm_*` inputs to status outputs.
- Zero-wait, `READ_LATENCY`=0: reset release at cycle 0 → REQ_ID at 1, REQ_TS at 2, CHECK at 3, `done`=1 at 4.
- Each extra latency cycle or wait cycle adds one cycle per read.
- `avm_address`/`avm_read` change only on clock edges and never while stalled.

## Configuration
- `SYSID_CHECKER_PERIODIC_EN` defined: a 26-bit counter runs in DONE and forces a restart (same as `start`) every `RECHECK_PERIOD` cycles; `start` also resets this counter.
- Undefined: no counter is built; the check runs only after reset and on `start`.

## Test plan
- Direct sysid model (ID 0, TS 1485989023), waitrequest 0, latency 0 → `done`=1 at cycle 4, `match`=1, `timestamp_value`=32'h5892649F.
- Slave returns TS 32'h12345678 → `done`=1, `match`=0, `mismatch_ts`=1, `mismatch_id`=0.
- `avm_waitrequest` held high, `TIMEOUT_CYCLES`=8 → `avm_read` drops after 8 stall cycles, `timeout`=1, `match`=0.
- `READ_LATENCY`=2 with waitrequest 3 cycles on the ID read → correct capture, `done` 7 cycles later than the zero-wait case; `start` pulse mid-run ignored.
- Reset asserted during LAT_TS → all outputs 0 that cycle; rerun after release yields `match`=1.
- Macro defined, `RECHECK_PERIOD`=100 → second `busy` rise exactly 100 cycles after the first `done`.
